// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the word-capable UART
//                transmitter. Holds the transmit FSM state encoding, the
//                character width and the line idle level.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LVL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte FIFO feeding the UART serialiser. One write can push
//                either a single byte or a whole 32-bit word (four bytes,
//                least significant byte first). Writes are judged against
//                the occupancy at the start of the cycle, so a same-cycle
//                pop never makes room for a push.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                i_wr_en/i_wr_data    - single byte push
//                i_wr_word_en/i_wr_word - four byte push (wins over byte)
//                i_rd_en/o_rd_data    - pop, head byte (valid when count!=0)
//                o_count/o_full/o_word_ok - registered occupancy flags
//                o_overflow           - registered pulse on a rejected write
//                o_empty_nxt          - occupancy after this edge is zero
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_wr_en,
    input  logic [7:0]                      i_wr_data,
    input  logic                            i_wr_word_en,
    input  logic [31:0]                     i_wr_word,
    input  logic                            i_rd_en,
    output logic [7:0]                      o_rd_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count,
    output logic                            o_full,
    output logic                            o_word_ok,
    output logic                            o_overflow,
    output logic                            o_empty_nxt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] c_depth    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] c_word_max = CW'(FIFO_DEPTH - 4);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_word_ok;
    logic          r_overflow;

    logic          w_push_byte;
    logic          w_push_word;
    logic          w_reject;
    logic [CW-1:0] w_count_nxt;

    always_comb begin
        // The word path always wins; a byte offered alongside it is lost.
        w_push_word = i_wr_word_en && r_word_ok;
        w_push_byte = i_wr_en && !i_wr_word_en && !r_full;
        w_reject    = (i_wr_word_en && (i_wr_en || !r_word_ok)) ||
                      (i_wr_en && !i_wr_word_en && r_full);
        w_count_nxt = r_count;
        if (w_push_word) w_count_nxt = w_count_nxt + CW'(4);
        if (w_push_byte) w_count_nxt = w_count_nxt + CW'(1);
        if (i_rd_en)     w_count_nxt = w_count_nxt - CW'(1);
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push_word) begin
            for (int k = 0; k < 4; k++) begin
                r_mem[r_wptr + AW'(k)] <= i_wr_word[8*k +: 8];
            end
        end else if (w_push_byte) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_word_ok  <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_word)      r_wptr <= r_wptr + AW'(4);
            else if (w_push_byte) r_wptr <= r_wptr + AW'(1);
            if (i_rd_en)          r_rptr <= r_rptr + AW'(1);
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == c_depth);
            r_word_ok  <= (w_count_nxt <= c_word_max);
            r_overflow <= w_reject;
        end
    end

    assign o_rd_data   = r_mem[r_rptr];
    assign o_count     = r_count;
    assign o_full      = r_full;
    assign o_word_ok   = r_word_ok;
    assign o_overflow  = r_overflow;
    assign o_empty_nxt = (w_count_nxt == '0);

endmodule
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_word_tx
//  Description : UART transmitter accepting bytes or 32-bit words. Bytes are
//                queued in uart_tx_fifo and sent 8N1/8N2, each bit lasting
//                OVERSAMPLE baud_tick pulses. Frames run back to back while
//                the FIFO holds data. All outputs come straight from flops.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                baud_tick         - oversampling enable, one clk wide
//                wr_en/wr_data     - push one byte
//                wr_word_en/wr_word - push four bytes, [7:0] first
//                tx                - serial line, idles high
//                busy              - frame running or FIFO non-empty
//                full/word_ok/count - FIFO status
//                overflow          - pulse on a rejected write
//                tx_done           - pulse after the last stop bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            baud_tick,
    input  logic                            wr_en,
    input  logic [7:0]                      wr_data,
    input  logic                            wr_word_en,
    input  logic [31:0]                     wr_word,
    output logic                            tx,
    output logic                            busy,
    output logic                            full,
    output logic                            word_ok,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
    output logic                            overflow,
    output logic                            tx_done
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [TW-1:0] c_tick_last = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_bit_last  = BW'(UART_DATA_BITS - 1);
    localparam logic          c_stop_last = (STOP_BITS == 2);

    uart_tx_state_t            r_state, w_state_nxt;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [TW-1:0]             r_tick, w_tick_nxt;
    logic [BW-1:0]             r_bit_idx, w_bit_idx_nxt;
    logic                      r_stop_idx, w_stop_idx_nxt;
    logic                      r_tx, w_tx_nxt;
    logic                      r_tx_done, w_tx_done_nxt;
    logic                      r_busy;

    logic       w_pop;
    logic       w_bit_end;
    logic       w_empty_nxt;
    logic [7:0] w_head;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_en      (wr_en),
        .i_wr_data    (wr_data),
        .i_wr_word_en (wr_word_en),
        .i_wr_word    (wr_word),
        .i_rd_en      (w_pop),
        .o_rd_data    (w_head),
        .o_count      (count),
        .o_full       (full),
        .o_word_ok    (word_ok),
        .o_overflow   (overflow),
        .o_empty_nxt  (w_empty_nxt)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_tick_nxt     = r_tick;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_tx_done_nxt  = 1'b0;
        w_pop          = 1'b0;
        w_bit_end      = baud_tick && (r_tick == c_tick_last);

        if (baud_tick && (r_state != IDLE)) begin
            w_tick_nxt = w_bit_end ? '0 : r_tick + TW'(1);
        end

        case (r_state)
            IDLE: begin
                w_pop = (count != '0);
            end
            START: begin
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_idx_nxt = r_bit_idx + BW'(1);
                    if (r_bit_idx == c_bit_last) begin
                        w_state_nxt    = STOP;
                        w_stop_idx_nxt = 1'b0;
                    end
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    if (r_stop_idx == c_stop_last) begin
                        w_tx_done_nxt = 1'b1;
                        w_state_nxt   = IDLE;
                        // Chain straight into the next start bit when data waits.
                        w_pop         = (count != '0);
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_pop) begin
            w_shift_nxt   = w_head;
            w_tick_nxt    = '0;
            w_bit_idx_nxt = '0;
            w_state_nxt   = START;
        end

        // tx is registered from the next state so the line changes with it.
        case (w_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_tick     <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_tx       <= UART_IDLE_LVL;
            r_tx_done  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_tick     <= w_tick_nxt;
            r_bit_idx  <= w_bit_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_tx       <= w_tx_nxt;
            r_tx_done  <= w_tx_done_nxt;
            r_busy     <= (w_state_nxt != IDLE) || !w_empty_nxt;
        end
    end

    assign tx      = r_tx;
    assign tx_done = r_tx_done;
    assign busy    = r_busy;

endmodule
`default_nettype wire
